// File: rtl/btn_pkg.sv
// Shared types and timing defaults for push-button conditioning blocks.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        PRESSED,
        WAIT_RELEASE
    } btn_state_t;

    localparam int unsigned DB_CYCLES_DEF     = 500000;
    localparam int unsigned REPEAT_DELAY_DEF  = 25000000;
    localparam int unsigned REPEAT_PERIOD_DEF = 5000000;

    // Counter width large enough for the longest of the three timing windows.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; resets to RESET_VAL.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_debounce_pulse.sv
// Debounces a raw button and emits one registered pulse per accepted press.
// Optional auto-repeat while held: define BTN_AUTOREPEAT_EN.
module btn_debounce_pulse
    import btn_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = DB_CYCLES_DEF,
    parameter int unsigned ACTIVE_LOW    = 0,
    parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic pulse
);

    localparam int unsigned CNT_W = cnt_width(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic        INV   = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic             btn_sync;
    logic             btn_s;
    btn_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             pulse_next;
    logic             level_next;

    // Sync flops reset to the not-pressed pin level for either polarity.
    sync_2ff #(
        .RESET_VAL(INV)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (btn_sync)
    );

    assign btn_s = btn_sync ^ INV;

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic rpt, rpt_next;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            pulse     <= 1'b0;
            btn_level <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rpt       <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            pulse     <= pulse_next;
            btn_level <= level_next;
`ifdef BTN_AUTOREPEAT_EN
            rpt       <= rpt_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pulse_next = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        rpt_next   = rpt;
`endif
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_next = WAIT_PRESS;
                    cnt_next   = '0;
                end
            end
            WAIT_PRESS: begin
                if (!btn_s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == DB_LAST) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                    pulse_next = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                    rpt_next   = 1'b0;
`endif
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_next = WAIT_RELEASE;
                    cnt_next   = '0;
                end
`ifdef BTN_AUTOREPEAT_EN
                // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
                else if (cnt == (rpt ? PER_LAST : DLY_LAST)) begin
                    pulse_next = 1'b1;
                    cnt_next   = '0;
                    rpt_next   = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
`endif
            end
            WAIT_RELEASE: begin
                if (btn_s) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
`ifdef BTN_AUTOREPEAT_EN
                    rpt_next   = 1'b0;
`endif
                end else if (cnt == DB_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
        level_next = (state_next == PRESSED) || (state_next == WAIT_RELEASE);
    end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Self-checking bench for btn_debounce_pulse with short debounce/repeat windows.
module tb_btn_debounce_pulse;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic btn_in = 1'b0;
    logic btn_level;
    logic pulse;

    int checks = 0;
    int errors = 0;

    btn_debounce_pulse #(
        .DB_CYCLES     (DB),
        .ACTIVE_LOW    (0),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .pulse     (pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: level flips after DB+1 consecutive synchronised samples opposing it;
    // a press flip emits a pulse; optional repeats count consecutive held samples.
    logic [1:0] m_sh  = 2'b00;
    logic       m_lvl = 1'b0;
    logic       m_pul = 1'b0;
    int         m_run = 0;
    int         m_h   = 0;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_sh  = 2'b00;
                m_lvl = 1'b0;
                m_pul = 1'b0;
                m_run = 0;
                m_h   = 0;
            end else begin
                logic s;
                s     = m_sh[1];
                m_pul = 1'b0;
                if (s != m_lvl) begin
                    m_run++;
                    if (m_run == DB + 1) begin
                        m_lvl = s;
                        m_run = 0;
                        if (s) begin
                            m_pul = 1'b1;
                            m_h   = 0;
                        end
                    end
                end else begin
`ifdef BTN_AUTOREPEAT_EN
                    if (m_lvl) begin
                        if (m_run != 0) m_h = 0;
                        else begin
                            m_h++;
                            if (m_h >= RD && ((m_h - RD) % RP) == 0) m_pul = 1'b1;
                        end
                    end
`endif
                    m_run = 0;
                end
                m_sh = {m_sh[0], btn_in};
            end
        end
    end

    // Per-cycle comparison against the model, plus the downstream 8-bit LED counter.
    logic [7:0] led_cnt = 8'h00;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("btn_level_vs_model", int'(btn_level), int'(m_lvl));
            check("pulse_vs_model", int'(pulse), int'(m_pul));
            if (reset) led_cnt = 8'h00;
            else if (pulse) led_cnt = led_cnt + 8'h01;
        end
    end

    int          h_np;
    int          h_fk;
    logic [63:0] h_lh;
    logic [63:0] h_ph;

    // Drive btn_in=v (reset released) at a negedge; record n following edges, k=0 first.
    task automatic hold(input logic v, input int n);
        @(negedge clk);
        btn_in = v;
        reset  = 1'b0;
        h_np = 0;
        h_fk = -1;
        h_lh = '0;
        h_ph = '0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #2;
            h_lh[k] = btn_level;
            h_ph[k] = pulse;
            if (pulse) begin
                if (h_np == 0) h_fk = k;
                h_np++;
            end
        end
    endtask

    initial begin
        int tot;
        repeat (3) @(posedge clk);
        #2;
        check("reset_level", int'(btn_level), 0);
        check("reset_pulse", int'(pulse), 0);
        hold(1'b0, 5);
        check("idle_no_pulse", h_np, 0);

        // Clean press held 40 cycles.
        hold(1'b1, 40);
        check("press_first_pulse_k", h_fk, 6);
        check("press_level_k5", int'(h_lh[5]), 0);
        check("press_level_k6", int'(h_lh[6]), 1);
        check("press_level_end", int'(h_lh[39]), 1);
`ifdef BTN_AUTOREPEAT_EN
        check("repeat_pulse_count", h_np, 9);
        check("repeat_gap", int'(h_ph[15:7]), 0);
        check("repeat_first_k16", int'(h_ph[16]), 1);
        check("repeat_second_k19", int'(h_ph[19]), 1);
`else
        check("press_single_pulse", h_np, 1);
`endif

        // Clean release.
        hold(1'b0, 10);
        check("release_no_pulse", h_np, 0);
        check("release_level_k5", int'(h_lh[5]), 1);
        check("release_level_k6", int'(h_lh[6]), 0);

        // Press bounce 1,0,1,0 then stay 0.
        tot = 0;
        hold(1'b1, 1); tot += h_np;
        hold(1'b0, 1); tot += h_np;
        hold(1'b1, 1); tot += h_np;
        hold(1'b0, 10); tot += h_np;
        check("bounce_no_pulse", tot, 0);
        check("bounce_level", int'(btn_level), 0);

        // Release bounce while pressed.
        hold(1'b1, 10);
        check("rb_press_pulse", h_np, 1);
        tot = 0;
        hold(1'b0, 2); tot += h_np;
        check("rb_level_low_phase", int'(&h_lh[1:0]), 1);
        hold(1'b1, 8); tot += h_np;
        check("rb_level_held", int'(&h_lh[7:0]), 1);
        check("rb_no_second_pulse", tot, 0);
        hold(1'b0, 8);
        check("rb_final_release", int'(h_lh[6]), 0);

        // Reset two cycles into a press, button kept held.
        hold(1'b1, 2);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_wp_level", int'(btn_level), 0);
        check("rst_wp_pulse", int'(pulse), 0);
        @(posedge clk);
        @(posedge clk);
        hold(1'b1, 10);
        check("rst_wp_pulse_k", h_fk, 6);
        check("rst_wp_pulse_cnt", h_np, 1);

        // Reset while pressed drops the level at once.
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_pr_level", int'(btn_level), 0);
        hold(1'b0, 12);
        check("rst_pr_no_pulse", h_np, 0);
        check("rst_pr_led_clear", int'(led_cnt), 0);

        // Downstream LED counter: 5 presses, then 256 total wraps.
        for (int i = 0; i < 5; i++) begin
            hold(1'b1, 10);
            hold(1'b0, 10);
        end
        check("led_count_5", int'(led_cnt), 5);
        for (int i = 0; i < 251; i++) begin
            hold(1'b1, 10);
            hold(1'b0, 10);
        end
        check("led_count_wrap", int'(led_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
